// File: rtl/vga_draw_arbiter.sv
// Arbitrates pixel bursts from several drawing channels onto one VGA adapter write port.
// One burst is served at a time; the winner streams pixels until last, request drop or idle timeout.
module vga_draw_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 3,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           ch_req,
  input  logic [NUM_CH-1:0]           ch_valid,
  input  logic [NUM_CH-1:0]           ch_last,
  input  logic [NUM_CH*X_W-1:0]       ch_x,
  input  logic [NUM_CH*Y_W-1:0]       ch_y,
  input  logic [NUM_CH*COLOR_W-1:0]   ch_color,
  output logic [NUM_CH-1:0]           grant,
  output logic                        plot,
  output logic [X_W-1:0]              x,
  output logic [Y_W-1:0]              y,
  output logic [COLOR_W-1:0]          color,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SUM_W = IDX_W + 1;
  localparam logic [16:0] TIMEOUT_C = 17'(TIMEOUT);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state_q, state_d;
  logic [NUM_CH-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]     last_winner_q, last_winner_d;
  logic [15:0]          idle_cnt_q, idle_cnt_d;
  logic                 plot_q, plot_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic                 timeout_err_q, timeout_err_d;

  logic [X_W-1:0]       x_arr     [NUM_CH];
  logic [Y_W-1:0]       y_arr     [NUM_CH];
  logic [COLOR_W-1:0]   color_arr [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign x_arr[gi]     = ch_x[gi*X_W +: X_W];
      assign y_arr[gi]     = ch_y[gi*Y_W +: Y_W];
      assign color_arr[gi] = ch_color[gi*COLOR_W +: COLOR_W];
    end
  endgenerate

  // last_winner_q only changes on burst entry, so it names the granted channel while in BURST.
  logic [IDX_W-1:0] sel;
  logic             accept;
  logic [16:0]      cnt_inc;

  assign sel     = last_winner_q;
  assign accept  = (state_q == BURST) && ch_valid[sel];
  assign cnt_inc = {1'b0, idle_cnt_q} + 17'd1;

  logic [IDX_W-1:0] winner;
  logic [SUM_W-1:0] rr_sum;
  logic [IDX_W-1:0] rr_idx;

  always_comb begin
    winner = '0;
    rr_sum = '0;
    rr_idx = '0;
    if (RR_MODE == 0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (ch_req[i]) winner = IDX_W'(i);
      end
    end else begin
      // Scan from farthest to nearest so the nearest requester after last_winner wins.
      for (int k = NUM_CH; k >= 1; k--) begin
        rr_sum = {1'b0, last_winner_q} + SUM_W'(k);
        if (rr_sum >= SUM_W'(NUM_CH)) rr_idx = IDX_W'(rr_sum - SUM_W'(NUM_CH));
        else                           rr_idx = rr_sum[IDX_W-1:0];
        if (ch_req[rr_idx]) winner = rr_idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_winner_d = last_winner_q;
    idle_cnt_d    = idle_cnt_q;
    plot_d        = 1'b0;
    x_d           = x_q;
    y_d           = y_q;
    color_d       = color_q;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d    = '0;
        idle_cnt_d = '0;
        if (|ch_req) begin
          state_d       = BURST;
          last_winner_d = winner;
          grant_d       = {{(NUM_CH-1){1'b0}}, 1'b1} << winner;
        end
      end
      BURST: begin
        if (accept) begin
          plot_d     = 1'b1;
          x_d        = x_arr[sel];
          y_d        = y_arr[sel];
          color_d    = color_arr[sel];
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = cnt_inc[15:0];
        end
        // Release precedence: last, then timeout, then request drop.
        if (accept && ch_last[sel]) begin
          state_d = IDLE;
          grant_d = '0;
        end else if (!accept && (cnt_inc == TIMEOUT_C)) begin
          state_d       = IDLE;
          grant_d       = '0;
          timeout_err_d = 1'b1;
        end else if (!ch_req[sel]) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_winner_q <= IDX_W'(NUM_CH - 1);
      idle_cnt_q    <= '0;
      plot_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      color_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_winner_q <= last_winner_d;
      idle_cnt_q    <= idle_cnt_d;
      plot_q        <= plot_d;
      x_q           <= x_d;
      y_q           <= y_d;
      color_q       <= color_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign plot        = plot_q;
  assign x           = x_q;
  assign y           = y_q;
  assign color       = color_q;
  assign busy        = (state_q == BURST);
  assign timeout_err = timeout_err_q;

endmodule
